// File: rtl/row_render_pipe.sv
// rtl/row_render_pipe.sv - two-stage row hit test with double-buffered texel slice store and shading
module row_render_pipe #(
   parameter int H_VIEW   = 640,
   parameter int SIZE_W   = 11,
   parameter int POS_W    = 10,
   parameter int TEX_BITS = 6,
   parameter int CH_W     = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  col_start,
   input  logic                  side,
   input  logic [SIZE_W-1:0]     size,
   input  logic                  vinf,
   input  logic [TEX_BITS-1:0]   leak,
   input  logic [3*CH_W-1:0]     bg_rgb,
   input  logic                  ld_valid,
   input  logic [3*CH_W-1:0]     ld_data,
   output logic                  ld_ready,
   input  logic                  px_valid,
   input  logic [POS_W-1:0]      hpos,
   input  logic [TEX_BITS-1:0]   texv,
   output logic                  o_valid,
   output logic                  o_hit,
   output logic [3*CH_W-1:0]     o_rgb,
   output logic                  underrun
);

   localparam int HALF  = H_VIEW / 2;
   localparam int RGB_W = 3 * CH_W;
   localparam int DEPTH = 2 ** TEX_BITS;
   localparam int SW    = ((SIZE_W > POS_W) ? SIZE_W : POS_W) + 2;
   localparam logic [TEX_BITS:0] FULL = (TEX_BITS + 1)'(DEPTH);

   // Bank b occupies mem[b*DEPTH +: DEPTH]; the load bank is always ~rbank.
   logic [RGB_W-1:0]    mem [0:2*DEPTH-1];
   logic [TEX_BITS:0]   cnt;
   logic                rbank;
   logic                l_side;
   logic                l_vinf;
   logic [SIZE_W-1:0]   l_size;
   logic [TEX_BITS-1:0] l_leak;

   logic                we;
   logic [TEX_BITS:0]   cnt_nxt;
   logic                full_nxt;

   assign we       = ld_valid & ld_ready;
   assign cnt_nxt  = cnt + {{TEX_BITS{1'b0}}, we};
   assign full_nxt = (cnt_nxt == FULL);

   always_ff @(posedge clk) begin
      if (we)
         mem[{~rbank, cnt[TEX_BITS-1:0]}] <= ld_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         rbank    <= 1'b0;
         ld_ready <= 1'b1;
         underrun <= 1'b0;
         l_side   <= 1'b0;
         l_vinf   <= 1'b0;
         l_size   <= '0;
         l_leak   <= '0;
      end else begin
         underrun <= 1'b0;
         cnt      <= cnt_nxt;
         ld_ready <= !full_nxt;
         if (col_start) begin
            l_side <= side;
            l_vinf <= vinf;
            l_size <= size;
            l_leak <= leak;
            // A final write in this same cycle still counts toward a full bank.
            if (full_nxt) begin
               rbank    <= ~rbank;
               cnt      <= '0;
               ld_ready <= 1'b1;
            end else begin
               underrun <= 1'b1;
            end
         end
      end
   end

   // Signed with headroom so HALF-size can go negative and HALF+size cannot overflow.
   logic signed [SW-1:0] s_half, s_hpos, s_size, s_lo, s_hi;
   logic                 hit_c;

   always_comb begin
      s_half = SW'(HALF);
      s_hpos = $signed({{(SW-POS_W){1'b0}}, hpos});
      s_size = $signed({{(SW-SIZE_W){1'b0}}, size == size ? l_size : l_size});
      s_lo   = s_half - s_size;
      s_hi   = s_half + s_size;
      hit_c  = (texv >= l_leak) &
               (l_vinf | (((s_hpos < s_half) | (texv != '0)) &
                          ((s_size > s_half) | ((s_lo <= s_hpos) & (s_hpos <= s_hi)))));
   end

   logic                s1_valid;
   logic                s1_hit;
   logic                s1_side;
   logic                s1_bank;
   logic [TEX_BITS-1:0] s1_texv;
   logic [RGB_W-1:0]    s1_bg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_hit   <= 1'b0;
         s1_side  <= 1'b0;
         s1_bank  <= 1'b0;
         s1_texv  <= '0;
         s1_bg    <= '0;
      end else begin
         s1_valid <= px_valid;
         if (px_valid) begin
            s1_hit  <= hit_c;
            s1_side <= l_side;
            s1_bank <= rbank;
            s1_texv <= texv;
            s1_bg   <= bg_rgb;
         end
      end
   end

   logic [RGB_W-1:0] texel;
   logic [RGB_W-1:0] shaded;

   always_comb begin
      texel  = mem[{s1_bank, s1_texv}];
      shaded = '0;
      for (int c = 0; c < 3; c++)
         shaded[c*CH_W +: CH_W] = texel[c*CH_W +: CH_W] >> 1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_valid <= 1'b0;
         o_hit   <= 1'b0;
         o_rgb   <= '0;
      end else begin
         o_valid <= s1_valid;
         if (s1_valid) begin
            o_hit <= s1_hit;
            if (!s1_hit)
               o_rgb <= s1_bg;
            else if (s1_side)
               o_rgb <= texel;
            else
               o_rgb <= shaded;
         end
      end
   end

endmodule

// File: tb/tb_row_render_pipe.sv
// tb/tb_row_render_pipe.sv - randomized bench for row_render_pipe against a cycle-level reference model
module tb_row_render_pipe;

   localparam int HALF  = 320;
   localparam int DEPTH = 64;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       col_start = 1'b0;
   logic       side = 1'b0;
   logic [10:0] size = '0;
   logic       vinf = 1'b0;
   logic [5:0] leak = '0;
   logic [5:0] bg_rgb = '0;
   logic       ld_valid = 1'b0;
   logic [5:0] ld_data = '0;
   logic       ld_ready;
   logic       px_valid = 1'b0;
   logic [9:0] hpos = '0;
   logic [5:0] texv = '0;
   logic       o_valid;
   logic       o_hit;
   logic [5:0] o_rgb;
   logic       underrun;

   row_render_pipe dut (
      .clk(clk), .reset_n(reset_n), .col_start(col_start), .side(side), .size(size),
      .vinf(vinf), .leak(leak), .bg_rgb(bg_rgb), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_ready(ld_ready), .px_valid(px_valid), .hpos(hpos), .texv(texv),
      .o_valid(o_valid), .o_hit(o_hit), .o_rgb(o_rgb), .underrun(underrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model state: two texel banks with written-flags, plus latched column params.
   int  mdata  [2][DEPTH];
   bit  mknown [2][DEPTH];
   int  m_rbank, m_cnt, m_size, m_leak;
   bit  m_ready, m_side, m_vinf;
   // Expected result of the pixel presented in the previous cycle, and the held output.
   bit  p_valid, p_hit, p_known;
   int  p_rgb;
   bit  h_hit, h_known;
   int  h_rgb;

   function automatic bit ref_hit(int hp, int tv, int sz, bit vi, int lk);
      bit in_span;
      in_span = (sz > HALF) || ((hp >= HALF - sz) && (hp <= HALF + sz));
      return (tv >= lk) && (vi || (((hp < HALF) || (tv != 0)) && in_span));
   endfunction

   function automatic int shade(int v);
      int r = 0;
      for (int c = 0; c < 3; c++)
         r += (((v >> (2 * c)) & 3) / 2) << (2 * c);
      return r;
   endfunction

   task automatic model_reset();
      m_rbank = 0; m_cnt = 0; m_ready = 1'b1;
      m_side = 1'b0; m_vinf = 1'b0; m_size = 0; m_leak = 0;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < DEPTH; i++)
            mknown[b][i] = 1'b0;
      p_valid = 1'b0; h_hit = 1'b0; h_rgb = 0; h_known = 1'b1;
   endtask

   task automatic idle();
      col_start = 1'b0; ld_valid = 1'b0; px_valid = 1'b0;
   endtask

   // One clock: predict from current inputs, advance the model, then check the DUT after the edge.
   task automatic step();
      bit e_valid, e_hit, e_known, e_under;
      int e_rgb, tx;
      e_valid = px_valid; e_hit = 1'b0; e_known = 1'b1; e_rgb = 0;
      if (px_valid) begin
         e_hit = ref_hit(int'(hpos), int'(texv), m_size, m_vinf, m_leak);
         if (e_hit) begin
            tx      = mdata[m_rbank][texv];
            e_known = mknown[m_rbank][texv];
            e_rgb   = m_side ? tx : shade(tx);
         end else begin
            e_rgb = int'(bg_rgb);
         end
      end
      if (ld_valid && m_ready) begin
         mdata[1-m_rbank][m_cnt]  = int'(ld_data);
         mknown[1-m_rbank][m_cnt] = 1'b1;
         m_cnt++;
      end
      e_under = 1'b0;
      if (col_start) begin
         m_side = side; m_vinf = vinf; m_size = int'(size); m_leak = int'(leak);
         if (m_cnt == DEPTH) begin
            m_rbank = 1 - m_rbank; m_cnt = 0;
         end else begin
            e_under = 1'b1;
         end
         m_ready = 1'b1;
      end else begin
         m_ready = (m_cnt < DEPTH);
      end
      @(posedge clk);
      #1;
      check("ld_ready", ld_ready, m_ready);
      check("underrun", underrun, e_under);
      check("o_valid", o_valid, p_valid);
      if (p_valid) begin
         h_hit = p_hit; h_rgb = p_rgb; h_known = p_known;
      end
      check("o_hit", o_hit, h_hit);
      if (h_known)
         check("o_rgb", o_rgb, h_rgb[5:0]);
      p_valid = e_valid; p_hit = e_hit; p_rgb = e_rgb; p_known = e_known;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      check("rst_o_valid", o_valid, 1'b0);
      check("rst_ld_ready", ld_ready, 1'b1);
      check("rst_underrun", underrun, 1'b0);
      check("rst_o_hit", o_hit, 1'b0);
      check("rst_o_rgb", o_rgb, 6'd0);
      model_reset();
      idle();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic rand_px();
      px_valid = ($urandom_range(0, 3) != 0);
      hpos     = 10'($urandom_range(0, 1023));
      texv     = 6'($urandom_range(0, 63));
      bg_rgb   = 6'($urandom_range(0, 63));
   endtask

   // mode 0: data = slot index, 1: random, 2: random with slot 5 = 6'b11_10_01
   task automatic load_n(int n, int mode, bit with_px);
      for (int j = 0; j < n; j++) begin
         ld_valid = 1'b1;
         ld_data  = (mode == 0) ? 6'(m_cnt) :
                    (mode == 2 && m_cnt == 5) ? 6'b111001 : 6'($urandom_range(0, 63));
         if (with_px) rand_px();
         step();
      end
      idle();
   endtask

   task automatic col(bit sd, int sz, bit vi, int lk);
      col_start = 1'b1; side = sd; size = 11'(sz); vinf = vi; leak = 6'(lk);
      step();
      idle();
   endtask

   task automatic pix(int hp, int tv);
      px_valid = 1'b1; hpos = 10'(hp); texv = 6'(tv);
      step();
      idle();
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();

      // Slice of texel = index, full-height light wall across the whole trace.
      load_n(64, 0, 1'b0);
      col(1'b1, 400, 1'b0, 0);
      for (int h = 0; h < 640; h++) begin
         bg_rgb = 6'($urandom_range(0, 63));
         px_valid = 1'b1; hpos = 10'(h); texv = 6'(h % 64);
         step();
      end
      idle();
      step(); step();

      // Span edges at size 100.
      load_n(64, 1, 1'b0);
      col(1'b1, 100, 1'b0, 0);
      bg_rgb = 6'b100100;
      pix(219, 219 % 64); pix(220, 220 % 64); pix(420, 420 % 64); pix(421, 421 % 64);
      step(); step();

      // Dark-side shading, then leak threshold above texv.
      load_n(64, 2, 1'b0);
      col(1'b0, 400, 1'b0, 0);
      pix(100, 5);
      col(1'b0, 400, 1'b0, 8);
      pix(100, 5);
      step(); step();

      // Partial load underruns, completion swaps.
      load_n(40, 1, 1'b1);
      col(1'b1, 300, 1'b0, 0);
      for (int k = 0; k < 4; k++) pix(k * 150, k * 7);
      load_n(24, 1, 1'b1);
      col(1'b1, 300, 1'b0, 0);
      for (int k = 0; k < 4; k++) pix(k * 150, k * 7);
      step(); step();

      // Last write, col_start and a pixel in one cycle; next pixel sees the new bank.
      load_n(63, 1, 1'b0);
      ld_valid = 1'b1; ld_data = 6'($urandom_range(0, 63));
      col_start = 1'b1; side = 1'b0; size = 11'd400; vinf = 1'b0; leak = 6'd0;
      px_valid = 1'b1; hpos = 10'd10; texv = 6'd3;
      step();
      idle();
      pix(10, 3);
      step(); step();

      // Reset mid-load with pixels in flight; the partial load is discarded.
      load_n(30, 1, 1'b1);
      px_valid = 1'b1;
      @(posedge clk);
      #2;
      do_reset();
      col(1'b1, 400, 1'b0, 0);
      load_n(64, 1, 1'b0);
      col(1'b1, 400, 1'b0, 0);
      for (int k = 0; k < 8; k++) pix(k * 40, k);
      step(); step();

      // Free-running random traffic.
      for (int n = 0; n < 4000; n++) begin
         ld_valid  = ($urandom_range(0, 3) != 0);
         ld_data   = 6'($urandom_range(0, 63));
         col_start = ($urandom_range(0, 69) == 0);
         side      = 1'($urandom_range(0, 1));
         size      = 11'($urandom_range(0, 2047));
         vinf      = ($urandom_range(0, 7) == 0);
         leak      = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
         rand_px();
         if ($urandom_range(0, 1999) == 0)
            do_reset();
         else
            step();
      end
      idle();
      step(); step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
